adder_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational WIDTH-bit Brent-Kung adder (built from half_adder/prefix cells) among NREQ requesters. Each requester presents operands with a valid/ready handshake. The block latches the winning request, drives the shared adder for one cycle, and registers the result. It then holds the result with the requester ID until the consumer accepts it. It sits between the ALU front-end ports and the single adder instance in the datapath.

---
 rtl/adder_arbiter.sv | 162 ++++++++++++++++
 tb/tb_adder_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// ---------------------------------------------------------------------------
// adder_arbiter
//
// Round-robin arbiter and sequencer in front of one shared combinational
// adder. One requester wins each time the block is idle. Its operands are
// latched and presented to the adder for one cycle. The sum and carry-out are
// then registered and held, together with the owner's index, until the
// consumer accepts them.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req_valid  [NREQ]        requester i has an operation pending
//   req_ready  [NREQ]        one-hot accept strobe (zero when nothing taken)
//   req_a/b    [NREQ*WIDTH]  operands, requester i at [i*WIDTH +: WIDTH]
//   req_cin    [NREQ]        carry-in per requester
//   add_a/b    [WIDTH]       operands driven to the shared adder
//   add_cin                  carry-in driven to the shared adder
//   add_sum    [WIDTH]       sum returned by the shared adder
//   add_cout                 carry-out returned by the shared adder
//   res_valid                result available
//   res_ready                consumer accepts the result
//   res_sum    [WIDTH]       registered sum
//   res_cout                 registered carry-out
//   res_id     [IDW]         index of the requester that owns the result
//   busy                     high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module adder_arbiter #(
  parameter  int WIDTH = 16,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_cin,
  input  logic [WIDTH-1:0]      add_sum,
  input  logic                  add_cout,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_sum,
  output logic                  res_cout,
  output logic [IDW-1:0]        res_id,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   id;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;

  logic             win_any;
  logic [IDW-1:0]   win_id;
  logic             accept;

  // (base + off) mod NREQ. Both terms are below NREQ, so one conditional
  // subtraction is enough, and unused indices (NREQ not a power of two) are
  // never produced.
  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base,
                                              input int             off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    return IDW'(sum);
  endfunction

  // Scan from the highest offset down so the last hit is the requester
  // closest to ptr, i.e. the first one in round-robin order.
  // NOTE: every always_comb output gets a default before any branch;
  // otherwise a path that skips an assignment infers a latch.
  always_comb begin
    win_any = 1'b0;
    win_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[rr_index(ptr, k)]) begin
        win_any = 1'b1;
        win_id  = rr_index(ptr, k);
      end
    end
  end

  assign accept = (state == IDLE) && win_any && !rst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win_id] = 1'b1;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (win_any)   state_d = CALC;
      CALC:                   state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Datapath registers. The reset sits inside the clocked block, so it is
  // synchronous and every register, including the operand latch, clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      id       <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_cin   <= 1'b0;
      res_sum  <= '0;
      res_cout <= 1'b0;
      res_id   <= '0;
    end else begin
      if (accept) begin
        op_a   <= req_a[win_id*WIDTH +: WIDTH];
        op_b   <= req_b[win_id*WIDTH +: WIDTH];
        op_cin <= req_cin[win_id];
        id     <= win_id;
      end
      if (state == CALC) begin
        res_sum  <= add_sum;
        res_cout <= add_cout;
        res_id   <= id;
      end
      // The owner of the retired result drops to lowest priority.
      if (state == DONE && res_ready) begin
        ptr <= (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
      end
    end
  end

  // The adder inputs follow the operand registers in every state, so they
  // change only at an accept edge.
  assign add_a     = op_a;
  assign add_b     = op_b;
  assign add_cin   = op_cin;

  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adder_arbiter
//
// Self-checking bench for adder_arbiter. The main instance uses WIDTH=16,
// NREQ=4; a second instance uses WIDTH=8, NREQ=3 for pointer wrap. The
// shared adder is modelled with plain arithmetic. The expected winner comes
// from a "last served" model: scan the requesters after the last one served.
// ---------------------------------------------------------------------------
module tb_adder_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // Main instance (WIDTH=16, NREQ=4)
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [3:0]  req_cin = '0;
  logic [15:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_sum;
  logic        res_cout;
  logic [1:0]  res_id;
  logic        busy;

  // Wrap instance (WIDTH=8, NREQ=3)
  logic [2:0]  req_valid3 = '0;
  logic [2:0]  req_ready3;
  logic [23:0] req_a3 = '0;
  logic [23:0] req_b3 = '0;
  logic [2:0]  req_cin3 = '0;
  logic [7:0]  add_a3, add_b3, add_sum3;
  logic        add_cin3, add_cout3;
  logic        res_valid3;
  logic        res_ready3 = 1'b0;
  logic [7:0]  res_sum3;
  logic        res_cout3;
  logic [1:0]  res_id3;
  logic        busy3;

  int checks   = 0;
  int failures = 0;
  int last     = 3;   // last served requester; reset ptr=0 means "3 was last"
  int last3    = 2;

  always #5 clk = ~clk;

  assign {add_cout, add_sum}   = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};
  assign {add_cout3, add_sum3} = {1'b0, add_a3} + {1'b0, add_b3} + {8'd0, add_cin3};

  adder_arbiter #(.WIDTH(16), .NREQ(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id),
    .busy(busy)
  );

  adder_arbiter #(.WIDTH(8), .NREQ(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .req_cin(req_cin3),
    .add_a(add_a3), .add_b(add_b3), .add_cin(add_cin3),
    .add_sum(add_sum3), .add_cout(add_cout3),
    .res_valid(res_valid3), .res_ready(res_ready3),
    .res_sum(res_sum3), .res_cout(res_cout3), .res_id(res_id3),
    .busy(busy3)
  );

  // First valid requester after the one served last, wrapping modulo n.
  function automatic int pick(input logic [7:0] v, input int prev, input int n);
    for (int k = 1; k <= n; k++) begin
      if (v[(prev + k) % n]) return (prev + k) % n;
    end
    return -1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst        = 1'b1;
    req_valid  = '0;
    req_valid3 = '0;
    res_ready  = 1'b0;
    res_ready3 = 1'b0;
    tick();
    tick();
    rst   = 1'b0;
    last  = 3;
    last3 = 2;
    #1;
  endtask

  // One complete transaction on the main instance using the operands already
  // on req_a/req_b/req_cin. hold = DONE cycles with res_ready low.
  task automatic serve(input logic [3:0] valid, input int hold);
    int          w;
    logic [3:0]  er;
    logic [15:0] ea, eb;
    logic        ec;
    logic [16:0] full;
    req_valid = valid;
    res_ready = 1'b0;
    #1;
    w    = pick({4'd0, valid}, last, 4);
    er   = '0;
    er[w] = 1'b1;
    ea   = req_a[w*16 +: 16];
    eb   = req_b[w*16 +: 16];
    ec   = req_cin[w];
    full = {1'b0, ea} + {1'b0, eb} + {16'd0, ec};
    if (req_ready !== er) begin failures++; $display("FAIL grant: got %b want %b", req_ready, er); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b want 0", busy); end
    checks++;
    tick();  // accept edge
    req_valid = 4'($urandom);
    #1;
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL calc_ready: got %b want 0000", req_ready); end
    checks++;
    if ({busy, res_valid} !== 2'b10) begin failures++; $display("FAIL calc_flags: got %b want 10", {busy, res_valid}); end
    checks++;
    if ({add_a, add_b, add_cin} !== {ea, eb, ec}) begin
      failures++; $display("FAIL adder_ops: got %h/%h/%b want %h/%h/%b", add_a, add_b, add_cin, ea, eb, ec);
    end
    checks++;
    tick();  // first DONE cycle
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin
        req_valid = 4'($urandom);
        tick();
      end
      if (res_valid !== 1'b1 || req_ready !== 4'b0000) begin
        failures++; $display("FAIL done_flags: got valid=%b ready=%b want 1/0000", res_valid, req_ready);
      end
      checks++;
      if ({res_cout, res_sum} !== full || res_id !== 2'(w)) begin
        failures++; $display("FAIL result: got %b/%h id %0d want %b/%h id %0d", res_cout, res_sum, res_id, full[16], full[15:0], w);
      end
      checks++;
    end
    res_ready = 1'b1;
    tick();  // retire edge
    res_ready = 1'b0;
    req_valid = '0;
    #1;
    if ({busy, res_valid} !== 2'b00) begin failures++; $display("FAIL retire_idle: got %b want 00", {busy, res_valid}); end
    checks++;
    last = w;
  endtask

  task automatic serve3(input logic [2:0] valid);
    int         w;
    logic [2:0] er;
    logic [8:0] full;
    req_valid3 = valid;
    #1;
    w     = pick({5'd0, valid}, last3, 3);
    er    = '0;
    er[w] = 1'b1;
    full  = {1'b0, req_a3[w*8 +: 8]} + {1'b0, req_b3[w*8 +: 8]} + {8'd0, req_cin3[w]};
    if (req_ready3 !== er) begin failures++; $display("FAIL wrap_grant: got %b want %b", req_ready3, er); end
    checks++;
    tick();
    req_valid3 = '0;
    tick();
    if (res_valid3 !== 1'b1 || {res_cout3, res_sum3} !== full || res_id3 !== 2'(w)) begin
      failures++; $display("FAIL wrap_result: got v=%b %b/%h id %0d want 1 %b/%h id %0d",
                           res_valid3, res_cout3, res_sum3, res_id3, full[8], full[7:0], w);
    end
    checks++;
    res_ready3 = 1'b1;
    tick();
    res_ready3 = 1'b0;
    last3 = w;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    req_valid = 4'b1111;
    tick();
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
    checks++;
    tick();
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL rst_ready2: got %b want 0000", req_ready); end
    checks++;
    if ({res_valid, busy, res_cout, res_id} !== 5'b0) begin
      failures++; $display("FAIL rst_flags: got %b want 00000", {res_valid, busy, res_cout, res_id});
    end
    checks++;
    if ({res_sum, add_a, add_b, add_cin} !== 49'b0) begin
      failures++; $display("FAIL rst_data: got %h/%h/%h/%b want 0", res_sum, add_a, add_b, add_cin);
    end
    checks++;
    req_valid = '0;
    rst       = 1'b0;
    last      = 3;
    last3     = 2;
    #1;
  endtask

  task automatic test_single;
    req_a[32 +: 16] = 16'hFFFF;
    req_b[32 +: 16] = 16'h0001;
    req_cin[2]      = 1'b0;
    serve(4'b0100, 0);
    if ({res_cout, res_sum, res_id} !== {1'b1, 16'h0000, 2'd2}) begin
      failures++; $display("FAIL single: got %b/%h id %0d want 1/0000 id 2", res_cout, res_sum, res_id);
    end
    checks++;
  endtask

  task automatic test_backpressure;
    req_a[16 +: 16] = 16'h1234;
    req_b[16 +: 16] = 16'h0F0F;
    req_cin[1]      = 1'b1;
    serve(4'b0010, 5);
    if ({res_cout, res_sum} !== {1'b0, 16'h2144}) begin
      failures++; $display("FAIL backpressure: got %b/%h want 0/2144", res_cout, res_sum);
    end
    checks++;
  endtask

  task automatic test_fairness;
    int order [6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      req_a   = {$urandom, $urandom};
      req_b   = {$urandom, $urandom};
      req_cin = 4'($urandom);
      serve(4'b1111, 0);
      if (res_id !== 2'(order[i])) begin
        failures++; $display("FAIL fair_order[%0d]: got %0d want %0d", i, res_id, order[i]);
      end
      checks++;
    end
  endtask

  task automatic test_reset_midop;
    do_reset();
    serve(4'b0100, 0);          // requester 2 served, so 3 is next in line
    req_valid = 4'b1000;
    #1;
    if (req_ready !== 4'b1000) begin failures++; $display("FAIL midop_grant: got %b want 1000", req_ready); end
    checks++;
    tick();                      // now in CALC for requester 3
    rst       = 1'b1;
    req_valid = 4'b1010;
    #1;
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL midop_rst_ready: got %b want 0000", req_ready); end
    checks++;
    tick();
    rst = 1'b0;
    #1;
    if ({res_valid, busy} !== 2'b00) begin failures++; $display("FAIL midop_idle: got %b want 00", {res_valid, busy}); end
    checks++;
    if (req_ready !== 4'b0010) begin failures++; $display("FAIL midop_regrant: got %b want 0010", req_ready); end
    checks++;
    last = 3;
    serve(4'b1010, 0);
  endtask

  task automatic test_wrap;
    int order [4] = '{2, 0, 2, 0};
    req_a3   = {$urandom};
    req_b3   = {$urandom};
    req_cin3 = 3'b101;
    for (int i = 0; i < 4; i++) begin
      serve3(i == 0 ? 3'b100 : 3'b101);
      if (res_id3 !== 2'(order[i])) begin
        failures++; $display("FAIL wrap_order[%0d]: got %0d want %0d", i, res_id3, order[i]);
      end
      checks++;
    end
  endtask

  task automatic test_random;
    logic [3:0] v;
    for (int i = 0; i < 40; i++) begin
      req_a   = {$urandom, $urandom};
      req_b   = {$urandom, $urandom};
      req_cin = 4'($urandom);
      v       = 4'($urandom_range(0, 15));
      if (v == 4'b0000) begin
        req_valid = '0;
        #1;
        if ({req_ready, busy} !== 5'b0) begin
          failures++; $display("FAIL rand_idle: got %b/%b want 0000/0", req_ready, busy);
        end
        checks++;
        tick();
      end else begin
        serve(v, $urandom_range(0, 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_fairness();
    test_reset_midop();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
